// File: rtl/elevator_pkg.sv
//==============================================================================
// Module      : elevator_pkg
// Description : Shared definitions for the elevator request scheduler and the
//               floor FSM it drives. Holds the floor encoding, the controller
//               state enum and the travel-direction constants.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    localparam logic [FLOOR_W-1:0] FLOOR0 = 2'd0;
    localparam logic [FLOOR_W-1:0] FLOOR1 = 2'd1;
    localparam logic [FLOOR_W-1:0] FLOOR2 = 2'd2;
    localparam logic [FLOOR_W-1:0] FLOOR3 = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // ST_EMERG is only reachable when the emergency option is built in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2,
        ST_EMERG = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/elevator_target_select.sv
//==============================================================================
// Module      : elevator_target_select
// Description : Combinational SCAN target picker. Keeps the current travel
//               direction while any request lies strictly ahead of the car;
//               otherwise reverses and takes the nearest request behind.
//               Requests at the car's own floor are never selected here.
// Ports       : pending_i    - request mask to choose from
//               floor_i      - current car floor
//               dir_up_i     - current travel direction (1 = up)
//               target_nxt_o - chosen floor (floor_i when nothing found)
//               dir_up_nxt_o - direction after the choice
//               found_o      - a request other than floor_i exists
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module elevator_target_select
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    input  logic                  dir_up_i,
    output logic [FLOOR_W-1:0]    target_nxt_o,
    output logic                  dir_up_nxt_o,
    output logic                  found_o
);

    logic                 w_found_up;
    logic                 w_found_dn;
    logic [FLOOR_W-1:0]   w_up_sel;
    logic [FLOOR_W-1:0]   w_dn_sel;

    // Descending scan above the car leaves the nearest floor above as the
    // final winner; ascending scan below leaves the nearest floor below.
    always_comb begin
        w_found_up = 1'b0;
        w_found_dn = 1'b0;
        w_up_sel   = floor_i;
        w_dn_sel   = floor_i;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && (i > int'(floor_i))) begin
                w_found_up = 1'b1;
                w_up_sel   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (i < int'(floor_i))) begin
                w_found_dn = 1'b1;
                w_dn_sel   = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        target_nxt_o = floor_i;
        dir_up_nxt_o = dir_up_i;
        found_o      = 1'b0;
        if (dir_up_i == DIR_UP) begin
            if (w_found_up) begin
                target_nxt_o = w_up_sel;
                found_o      = 1'b1;
            end else if (w_found_dn) begin
                target_nxt_o = w_dn_sel;
                dir_up_nxt_o = DIR_DOWN;
                found_o      = 1'b1;
            end
        end else begin
            if (w_found_dn) begin
                target_nxt_o = w_dn_sel;
                found_o      = 1'b1;
            end else if (w_found_up) begin
                target_nxt_o = w_up_sel;
                dir_up_nxt_o = DIR_UP;
                found_o      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
//==============================================================================
// Module      : elevator_request_scheduler
// Description : Latches hall/car calls, dispatches the floor FSM with a SCAN
//               policy and holds the car with the door open at each served
//               floor for DWELL_CYCLES before clearing that call.
// Option      : ELEVATOR_EMERGENCY_EN - adds emergency_i and the EMERG state
//               (car held, door shut, calls still latched, dwell frozen).
// Ports       : clock_i     - clock, rising edge
//               reset_i     - asynchronous active-high reset
//               emergency_i - emergency hold (option only)
//               call_i      - per-floor call buttons
//               floor_i     - current floor from the floor FSM
//               target_o    - target floor to the FSM
//               stop_o      - 1 = FSM must not move
//               door_open_o - door open during dwell
//               pending_o   - latched request mask (call lamps)
//               dir_up_o    - travel direction, 1 = up
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
`ifdef ELEVATOR_EMERGENCY_EN
    input  logic                  emergency_i,
`endif
    input  logic [NUM_FLOORS-1:0] call_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic [FLOOR_W-1:0]    target_o,
    output logic                  stop_o,
    output logic                  door_open_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  dir_up_o
);

    localparam int               CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_e                 state_q,   state_d;
    logic [NUM_FLOORS-1:0]  pending_q, pending_d;
    logic [FLOOR_W-1:0]     target_q,  target_d;
    logic                   stop_q,    stop_d;
    logic                   door_q,    door_d;
    logic                   dir_up_q,  dir_up_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;

    logic [NUM_FLOORS-1:0]  w_sel_pending;
    logic [NUM_FLOORS-1:0]  w_call_eff;
    logic [FLOOR_W-1:0]     w_tgt_nxt;
    logic                   w_dir_nxt;
    logic                   w_found;

    // While travelling, calls arriving this cycle are folded into the choice
    // so a floor appearing just ahead of the car can still be stopped at;
    // waiting for the latch would let the FSM step past it. IDLE dispatch
    // works from the latched mask only.
    assign w_sel_pending = (state_q == ST_MOVE) ? (pending_q | call_i) : pending_q;

    elevator_target_select u_target_select (
        .pending_i    (w_sel_pending),
        .floor_i      (floor_i),
        .dir_up_i     (dir_up_q),
        .target_nxt_o (w_tgt_nxt),
        .dir_up_nxt_o (w_dir_nxt),
        .found_o      (w_found)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        stop_d    = stop_q;
        door_d    = door_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;

        // A press at the floor being served only re-opens the door.
        w_call_eff = call_i;
        if (state_q == ST_DWELL) begin
            w_call_eff[floor_i] = 1'b0;
        end
        pending_d = pending_q | w_call_eff;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b1;
                door_d = 1'b0;
                if (pending_q[floor_i]) begin
                    state_d  = ST_DWELL;
                    door_d   = 1'b1;
                    cnt_d    = c_DWELL_LAST;
                    target_d = floor_i;
                end else if (w_found) begin
                    state_d  = ST_MOVE;
                    stop_d   = 1'b0;
                    target_d = w_tgt_nxt;
                    dir_up_d = w_dir_nxt;
                end
            end

            ST_MOVE: begin
                if (floor_i == target_q) begin
                    state_d = ST_DWELL;
                    stop_d  = 1'b1;
                    door_d  = 1'b1;
                    cnt_d   = c_DWELL_LAST;
                end else begin
                    stop_d = 1'b0;
                    if (w_found) begin
                        target_d = w_tgt_nxt;
                        dir_up_d = w_dir_nxt;
                    end
                end
            end

            ST_DWELL: begin
                stop_d = 1'b1;
                door_d = 1'b1;
                if (call_i[floor_i]) begin
                    cnt_d = c_DWELL_LAST;
                end else if (cnt_q == '0) begin
                    pending_d[floor_i] = 1'b0;
                    state_d            = ST_IDLE;
                    door_d             = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

`ifdef ELEVATOR_EMERGENCY_EN
            ST_EMERG: begin
                stop_d = 1'b1;
                door_d = 1'b0;
                if (!emergency_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                stop_d  = 1'b1;
                door_d  = 1'b0;
            end
        endcase

`ifdef ELEVATOR_EMERGENCY_EN
        // Emergency overrides everything: requests keep accumulating but
        // none is cleared, and the dwell count is held where it was.
        if (emergency_i) begin
            state_d   = ST_EMERG;
            stop_d    = 1'b1;
            door_d    = 1'b0;
            target_d  = target_q;
            dir_up_d  = dir_up_q;
            cnt_d     = cnt_q;
            pending_d = pending_q | call_i;
        end
`endif
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            target_q  <= FLOOR0;
            stop_q    <= 1'b1;
            door_q    <= 1'b0;
            dir_up_q  <= DIR_UP;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            stop_q    <= stop_d;
            door_q    <= door_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_o    = target_q;
    assign stop_o      = stop_q;
    assign door_open_o = door_q;
    assign pending_o   = pending_q;
    assign dir_up_o    = dir_up_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
//==============================================================================
// Module      : tb_elevator_request_scheduler
// Description : Self-checking bench for elevator_request_scheduler with a
//               one-floor-per-cycle floor FSM model as the plant. Directed
//               scenarios plus randomized call masks checked against a SCAN
//               service-order and timing model.
// Option      : ELEVATOR_EMERGENCY_EN enables the emergency scenario.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_elevator_request_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] call  = 4'b0;
    logic [1:0] floor;
    logic [1:0] target;
    logic       stop;
    logic       door_open;
    logic [3:0] pending;
    logic       dir_up;
`ifdef ELEVATOR_EMERGENCY_EN
    logic       emergency = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    int r_edge[$];
    int r_fl[$];
    int r_dir[$];
    int door_cnt;
    int stop_bad;
    int move_cnt;

    elevator_request_scheduler #(.DWELL_CYCLES(8)) dut (
        .clock_i     (clock),
        .reset_i     (reset),
`ifdef ELEVATOR_EMERGENCY_EN
        .emergency_i (emergency),
`endif
        .call_i      (call),
        .floor_i     (floor),
        .target_o    (target),
        .stop_o      (stop),
        .door_open_o (door_open),
        .pending_o   (pending),
        .dir_up_o    (dir_up)
    );

    always #5 clock = ~clock;

    // Floor FSM plant: one floor per cycle toward target while stop is low.
    always @(posedge clock or posedge reset) begin
        if (reset)
            floor <= 2'd0;
        else if (!stop && (floor < target))
            floor <= floor + 2'd1;
        else if (!stop && (floor > target))
            floor <= floor - 2'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        call  = 4'b0;
`ifdef ELEVATOR_EMERGENCY_EN
        emergency = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
    endtask

    // Advances ncyc edges numbered from n0, logging door-open rising edges.
    task automatic watch(input int n0, input int ncyc, input bit clr);
        logic prev;
        if (clr) begin
            r_edge.delete(); r_fl.delete(); r_dir.delete();
            door_cnt = 0; stop_bad = 0; move_cnt = 0;
        end
        for (int n = n0; n < n0 + ncyc; n++) begin
            prev = door_open;
            step();
            if (door_open && !prev) begin
                r_edge.push_back(n); r_fl.push_back(int'(floor)); r_dir.push_back(int'(dir_up));
            end
            if (door_open) door_cnt++;
            if (door_open && !stop) stop_bad++;
            if (!stop) move_cnt++;
        end
    endtask

    // Pulses a call mask and waits (bounded) until everything is served.
    task automatic serve(input logic [3:0] m, output bit ok);
        ok = 1'b0;
        call = m;
        step();
        call = 4'b0;
        for (int n = 0; n < 120; n++) begin
            step();
            if (pending == 4'b0 && !door_open && stop) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // SCAN choice: nearest request ahead, otherwise nearest behind (reversing).
    function automatic int pick(input logic [3:0] s, input int f, input bit d, output bit nd);
        int t;
        int c;
        t  = -1;
        nd = d;
        for (int k = 1; k < 4; k++) begin
            c = d ? f + k : f - k;
            if (t < 0 && c >= 0 && c < 4 && s[2'(c)]) t = c;
        end
        if (t < 0) begin
            nd = !d;
            for (int k = 1; k < 4; k++) begin
                c = nd ? f + k : f - k;
                if (t < 0 && c >= 0 && c < 4 && s[2'(c)]) t = c;
            end
        end
        return t;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_cmp++; if (pending !== 4'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        n_cmp++; if (target !== 2'd0) begin n_fail++; $display("FAIL reset_target: got %0d expected 0", target); end
        n_cmp++; if (stop !== 1'b1) begin n_fail++; $display("FAIL reset_stop: got %b expected 1", stop); end
        n_cmp++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL reset_door: got %b expected 0", door_open); end
        n_cmp++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b expected 1", dir_up); end
        reset = 1'b0;
        step();
        step();
        n_cmp++; if (stop !== 1'b1 || pending !== 4'b0) begin n_fail++; $display("FAIL idle_after_reset: stop %b pending %b expected 1 0000", stop, pending); end
    endtask

    task automatic test_basic();
        int idle_bad;
        do_reset();
        call = 4'b1000;
        step();
        call = 4'b0;
        n_cmp++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL basic_latch: got %b expected 1000", pending); end
        n_cmp++; if (stop !== 1'b1) begin n_fail++; $display("FAIL basic_stop_latch: got %b expected 1", stop); end
        step();
        n_cmp++; if (stop !== 1'b0 || target !== 2'd3) begin n_fail++; $display("FAIL basic_dispatch: stop %b target %0d expected 0 3", stop, target); end
        watch(2, 28, 1'b1);
        n_cmp++; if (r_edge.size() != 1) begin n_fail++; $display("FAIL basic_rises: got %0d expected 1", r_edge.size()); end
        if (r_edge.size() > 0) begin
            n_cmp++; if (r_edge[0] != 5 || r_fl[0] != 3) begin n_fail++; $display("FAIL basic_arrive: edge %0d floor %0d expected 5 3", r_edge[0], r_fl[0]); end
        end
        n_cmp++; if (door_cnt != 8) begin n_fail++; $display("FAIL basic_dwell_len: got %0d expected 8", door_cnt); end
        n_cmp++; if (stop_bad != 0) begin n_fail++; $display("FAIL basic_door_stop: got %0d expected 0", stop_bad); end
        n_cmp++; if (pending !== 4'b0) begin n_fail++; $display("FAIL basic_cleared: got %b expected 0000", pending); end
        idle_bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (stop !== 1'b1) idle_bad++;
        end
        n_cmp++; if (idle_bad != 0) begin n_fail++; $display("FAIL basic_idle_stop: got %0d expected 0", idle_bad); end
    endtask

    task automatic test_retarget();
        do_reset();
        call = 4'b1000;
        step();
        call = 4'b0;
        step();
        step();
        n_cmp++; if (floor !== 2'd1) begin n_fail++; $display("FAIL retgt_floor1: got %0d expected 1", floor); end
        call = 4'b0100;
        step();
        call = 4'b0;
        n_cmp++; if (target !== 2'd2 || pending !== 4'b1100) begin n_fail++; $display("FAIL retgt_target: target %0d pending %b expected 2 1100", target, pending); end
        watch(4, 30, 1'b1);
        n_cmp++; if (r_edge.size() != 2) begin n_fail++; $display("FAIL retgt_rises: got %0d expected 2", r_edge.size()); end
        if (r_edge.size() == 2) begin
            n_cmp++; if (r_edge[0] != 4 || r_fl[0] != 2) begin n_fail++; $display("FAIL retgt_first: edge %0d floor %0d expected 4 2", r_edge[0], r_fl[0]); end
            n_cmp++; if (r_edge[1] != 15 || r_fl[1] != 3) begin n_fail++; $display("FAIL retgt_second: edge %0d floor %0d expected 15 3", r_edge[1], r_fl[1]); end
        end
        n_cmp++; if (pending !== 4'b0) begin n_fail++; $display("FAIL retgt_cleared: got %b expected 0000", pending); end
    endtask

    task automatic test_scan();
        bit ok;
        do_reset();
        serve(4'b0100, ok);
        n_cmp++; if (!ok || floor !== 2'd2 || dir_up !== 1'b1) begin n_fail++; $display("FAIL scan_setup: ok %0d floor %0d dir %b expected 1 2 1", ok, floor, dir_up); end
        call = 4'b1001;
        step();
        call = 4'b0;
        watch(1, 40, 1'b1);
        n_cmp++; if (r_edge.size() != 2) begin n_fail++; $display("FAIL scan_rises: got %0d expected 2", r_edge.size()); end
        if (r_edge.size() == 2) begin
            n_cmp++; if (r_fl[0] != 3 || r_edge[0] != 3) begin n_fail++; $display("FAIL scan_first: floor %0d edge %0d expected 3 3", r_fl[0], r_edge[0]); end
            n_cmp++; if (r_fl[1] != 0 || r_edge[1] != 16 || r_dir[1] != 0) begin n_fail++; $display("FAIL scan_second: floor %0d edge %0d dir %0d expected 0 16 0", r_fl[1], r_edge[1], r_dir[1]); end
        end
        n_cmp++; if (pending !== 4'b0) begin n_fail++; $display("FAIL scan_cleared: got %b expected 0000", pending); end
    endtask

    task automatic test_repress();
        bit ok;
        do_reset();
        serve(4'b0010, ok);
        n_cmp++; if (!ok || floor !== 2'd1) begin n_fail++; $display("FAIL repress_setup: ok %0d floor %0d expected 1 1", ok, floor); end
        call = 4'b0010;
        step();
        call = 4'b0;
        watch(1, 5, 1'b1);
        call = 4'b0010;
        watch(6, 1, 1'b0);
        call = 4'b0;
        watch(7, 20, 1'b0);
        n_cmp++; if (r_edge.size() != 1) begin n_fail++; $display("FAIL repress_rises: got %0d expected 1", r_edge.size()); end
        if (r_edge.size() > 0) begin
            n_cmp++; if (r_edge[0] != 1) begin n_fail++; $display("FAIL repress_entry: edge %0d expected 1", r_edge[0]); end
        end
        n_cmp++; if (door_cnt != 13) begin n_fail++; $display("FAIL repress_door_len: got %0d expected 13", door_cnt); end
        n_cmp++; if (move_cnt != 0 || floor !== 2'd1) begin n_fail++; $display("FAIL repress_moved: moving cycles %0d floor %0d expected 0 1", move_cnt, floor); end
        n_cmp++; if (pending !== 4'b0) begin n_fail++; $display("FAIL repress_cleared: got %b expected 0000", pending); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        call = 4'b1000;
        step();
        call = 4'b0;
        step();
        step();
        n_cmp++; if (stop !== 1'b0 || floor !== 2'd1) begin n_fail++; $display("FAIL rstmid_moving: stop %b floor %0d expected 0 1", stop, floor); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (pending !== 4'b0 || stop !== 1'b1 || target !== 2'd0 || door_open !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_clear: pending %b stop %b target %0d door %b expected 0000 1 0 0", pending, stop, target, door_open);
        end
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef ELEVATOR_EMERGENCY_EN
    task automatic test_emergency();
        do_reset();
        call = 4'b1000;
        step();
        call = 4'b0;
        step();
        step();
        emergency = 1'b1;
        step();
        n_cmp++; if (stop !== 1'b1 || pending !== 4'b1000 || door_open !== 1'b0) begin n_fail++; $display("FAIL emerg_hold: stop %b pending %b door %b expected 1 1000 0", stop, pending, door_open); end
        call = 4'b0001;
        step();
        call = 4'b0;
        step();
        step();
        n_cmp++; if (floor !== 2'd2 || pending !== 4'b1001 || stop !== 1'b1) begin n_fail++; $display("FAIL emerg_frozen: floor %0d pending %b stop %b expected 2 1001 1", floor, pending, stop); end
        emergency = 1'b0;
        step();
        step();
        n_cmp++; if (stop !== 1'b0 || target !== 2'd3) begin n_fail++; $display("FAIL emerg_resume: stop %b target %0d expected 0 3", stop, target); end
        watch(0, 40, 1'b1);
        n_cmp++; if (r_edge.size() != 2) begin n_fail++; $display("FAIL emerg_rises: got %0d expected 2", r_edge.size()); end
        if (r_edge.size() == 2) begin
            n_cmp++; if (r_fl[0] != 3 || r_fl[1] != 0) begin n_fail++; $display("FAIL emerg_order: floors %0d %0d expected 3 0", r_fl[0], r_fl[1]); end
        end
        n_cmp++; if (pending !== 4'b0) begin n_fail++; $display("FAIL emerg_cleared: got %b expected 0000", pending); end
    endtask
`endif

    task automatic test_random();
        int   mf;
        bit   md;
        logic [3:0] m;
        logic [3:0] s;
        int   f, e, t, rise, lim;
        bit   d, nd;
        int   exp_e[$];
        int   exp_f[$];
        do_reset();
        mf = 0;
        md = 1'b1;
        for (int it = 0; it < 20; it++) begin
            m = 4'($urandom_range(1, 15));
            exp_e.delete();
            exp_f.delete();
            s = m; f = mf; d = md; e = 1;
            // Each service: door opens D+1 edges after dispatch (or at once
            // for the car's own floor), and the next decision comes 9 edges
            // after the door opens.
            while (s != 4'b0) begin
                if (s[2'(f)]) begin
                    t = f;
                    rise = e;
                end else begin
                    t = pick(s, f, d, nd);
                    d = nd;
                    rise = e + ((t > f) ? t - f : f - t) + 1;
                end
                exp_e.push_back(rise);
                exp_f.push_back(t);
                s[2'(t)] = 1'b0;
                f = t;
                e = rise + 9;
            end
            call = m;
            step();
            call = 4'b0;
            n_cmp++; if (pending !== m) begin n_fail++; $display("FAIL rnd_latch[%0d]: got %b expected %b", it, pending, m); end
            watch(1, exp_e[exp_e.size()-1] + 12, 1'b1);
            n_cmp++; if (r_edge.size() != exp_e.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d mask %b", it, r_edge.size(), exp_e.size(), m); end
            lim = (r_edge.size() < exp_e.size()) ? r_edge.size() : exp_e.size();
            for (int k = 0; k < lim; k++) begin
                n_cmp++; if (r_edge[k] != exp_e[k] || r_fl[k] != exp_f[k]) begin
                    n_fail++; $display("FAIL rnd_service[%0d.%0d]: edge %0d floor %0d expected %0d %0d", it, k, r_edge[k], r_fl[k], exp_e[k], exp_f[k]);
                end
            end
            n_cmp++; if (pending !== 4'b0 || door_open !== 1'b0 || dir_up !== d) begin
                n_fail++; $display("FAIL rnd_end[%0d]: pending %b door %b dir %b expected 0000 0 %b", it, pending, door_open, dir_up, d);
            end
            mf = f;
            md = d;
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retarget();
        test_scan();
        test_repress();
        test_reset_mid_move();
`ifdef ELEVATOR_EMERGENCY_EN
        test_emergency();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
